// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches the segment and anode lines of a multiplexed 4-digit 7-segment
// display and recovers the displayed BCD digits. A digit is captured only
// after its select and segment lines have held steady for STABLE_CYCLES
// sampled cycles. Each steady dwell produces exactly one capture.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | sampled anode select is not one-hot; nothing is captured
// SETTLE   | one-hot select seen; counting consecutive unchanged samples
// CAPTURED | digit captured for this dwell; wait for the next change
`timescale 1ns/1ps

module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    input  logic        LED_type_ctl,
    output logic [15:0] bcd_out,
    output logic [3:0]  digit_valid,
    output logic [3:0]  err_digit,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

    // sample word layout: {an[11:8], seg[7:1], led_type[0]}
    logic [11:0] sample_q, sample_d;
    logic [11:0] prev_q, prev_d;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  err_q, err_d;
    logic        frame_q, frame_d;

    logic [3:0]  an_s;
    logic [6:0]  norm;
    logic        legal;
    logic [3:0]  digit;
    logic        capture;
    logic [3:0]  mask_next;

    // Normalize the sampled segments to active-high and decode them.
    always_comb begin
        an_s  = sample_q[11:8];
        norm  = sample_q[0] ? sample_q[7:1] : ~sample_q[7:1];
        legal = 1'b1;
        digit = 4'hF;
        case (norm)
            7'b1111110: digit = 4'd0;
            7'b0110000: digit = 4'd1;
            7'b1101101: digit = 4'd2;
            7'b1111001: digit = 4'd3;
            7'b0110011: digit = 4'd4;
            7'b1011011: digit = 4'd5;
            7'b1011111: digit = 4'd6;
            7'b1110000: digit = 4'd7;
            7'b1111111: digit = 4'd8;
            7'b1111011: digit = 4'd9;
            default: begin
                legal = 1'b0;
                digit = 4'hF;
            end
        endcase
    end

    // Next-state logic: dwell tracking, capture, and frame bookkeeping.
    always_comb begin
        sample_d  = {an_in, seg_in, LED_type_ctl};
        prev_d    = sample_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        bcd_d     = bcd_q;
        valid_d   = valid_q;
        err_d     = err_q;
        frame_d   = 1'b0;
        capture   = 1'b0;
        mask_next = mask_q | an_s;

        if (sample_q != prev_q) begin
            if (!$onehot(an_s)) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else begin
                state_d = SETTLE;
                cnt_d   = 4'd1;
                capture = (STABLE_C == 4'd1);
            end
        end else begin
            case (state_q)
                IDLE:     cnt_d = 4'd0;
                SETTLE: begin
                    cnt_d   = cnt_q + 4'd1;
                    capture = ((cnt_q + 4'd1) == STABLE_C);
                end
                CAPTURED: cnt_d = STABLE_C;
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        if (capture) begin
            state_d = CAPTURED;
            cnt_d   = STABLE_C;
            for (int i = 0; i < 4; i++) begin
                if (an_s[i]) begin
                    bcd_d[4*i +: 4] = digit;
                    valid_d[i]      = legal;
                    err_d[i]        = ~legal;
                end
            end
            if (mask_next == 4'hF) begin
                frame_d = 1'b1;
                mask_d  = 4'h0;
            end else begin
                mask_d  = mask_next;
            end
        end
    end

    // Register all state; reset clears every flop including the sample stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
            prev_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            bcd_q    <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            frame_q  <= 1'b0;
        end else begin
            sample_q <= sample_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_valid = valid_q;
    assign err_digit   = err_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed testbench for seg7_scan_decoder with an expected-result queue.
`timescale 1ns/1ps

module tb_seg7_scan_decoder;

    localparam int S = 4;

    localparam logic [6:0] PAT [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  v;
        logic [3:0]  e;
        logic        f;
        logic [3:0]  mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  an_in = '0;
    logic        LED_type_ctl = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic [3:0]  err_digit;
    logic        frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t        sb[$];
    logic [15:0] m_bcd;
    logic [3:0]  m_v, m_e, m_mask;
    logic [11:0] last;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .an_in        (an_in),
        .LED_type_ctl (LED_type_ctl),
        .bcd_out      (bcd_out),
        .digit_valid  (digit_valid),
        .err_digit    (err_digit),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // returns {legal, digit}
    function automatic logic [4:0] dec(input logic [6:0] p);
        for (int k = 0; k < 10; k++)
            if (PAT[k] == p) return {1'b1, 4'(k)};
        return {1'b0, 4'hF};
    endfunction

    task automatic check(input string tag, input logic [15:0] b,
                         input logic [3:0] v, input logic [3:0] e, input logic f);
        n_assert++;
        assert (bcd_out === b) else begin
            n_fail++;
            $error("FAIL %s bcd_out observed=%h expected=%h", tag, bcd_out, b);
        end
        n_assert++;
        assert (digit_valid === v) else begin
            n_fail++;
            $error("FAIL %s digit_valid observed=%b expected=%b", tag, digit_valid, v);
        end
        n_assert++;
        assert (err_digit === e) else begin
            n_fail++;
            $error("FAIL %s err_digit observed=%b expected=%b", tag, err_digit, e);
        end
        n_assert++;
        assert (frame_done === f) else begin
            n_fail++;
            $error("FAIL %s frame_done observed=%b expected=%b", tag, frame_done, f);
        end
    endtask

    // Hold one input pattern for n cycles. pat is the active-high pattern;
    // ct selects cathode (1) or anode (0) drive polarity.
    task automatic hold(input string tag, input logic [3:0] an,
                        input logic [6:0] pat, input logic ct, input int n);
        logic [6:0] seg;
        logic [4:0] r;
        logic       cap;
        exp_t       x;
        seg = ct ? pat : ~pat;
        cap = $onehot(an) && (n >= S + 1) && ({an, seg, ct} != last);
        if (cap) begin
            r = dec(pat);
            x.bcd = m_bcd; x.v = m_v; x.e = m_e;
            for (int i = 0; i < 4; i++) begin
                if (an[i]) begin
                    x.bcd[4*i +: 4] = r[3:0];
                    x.v[i] = r[4];
                    x.e[i] = ~r[4];
                end
            end
            x.mask = m_mask | an;
            x.f    = (x.mask == 4'hF);
            if (x.f) x.mask = 4'h0;
            sb.push_back(x);
        end
        an_in = an; seg_in = seg; LED_type_ctl = ct;
        last = {an, seg, ct};
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (cap && c == S + 1) begin
                x = sb.pop_front();
                m_bcd = x.bcd; m_v = x.v; m_e = x.e; m_mask = x.mask;
                check($sformatf("%s capture edge %0d", tag, c), m_bcd, m_v, m_e, x.f);
            end else begin
                check($sformatf("%s edge %0d", tag, c), m_bcd, m_v, m_e, 1'b0);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        an_in = '0; seg_in = '0; LED_type_ctl = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_bcd = '0; m_v = '0; m_e = '0; m_mask = '0; last = '0;
        check({tag, " async"}, 16'h0000, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check({tag, " released"}, 16'h0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    initial begin
        m_bcd = '0; m_v = '0; m_e = '0; m_mask = '0; last = '0;
        do_reset("reset");

        // cathode digit 0 = 0, capture on edge 5 only
        hold("cc_d0_zero", 4'b0001, PAT[0], 1'b1, 5);

        // anode frame 9,5,2,7 -> 7259 with frame pulse on digit 3
        hold("ca_d0_9", 4'b0001, PAT[9], 1'b0, 6);
        hold("ca_d1_5", 4'b0010, PAT[5], 1'b0, 6);
        hold("ca_d2_2", 4'b0100, PAT[2], 1'b0, 6);
        hold("ca_d3_7", 4'b1000, PAT[7], 1'b0, 6);

        // illegal pattern on digit 2
        hold("cc_d2_illegal", 4'b0100, 7'b1010101, 1'b1, 5);

        // short toggling dwells then one steady dwell
        for (int t = 0; t < 4; t++)
            hold("toggle", 4'b0010, (t % 2 == 0) ? PAT[3] : PAT[8], 1'b1, 3);
        hold("toggle_settle", 4'b0010, PAT[3], 1'b1, 5);

        // non-one-hot selects never capture
        hold("an_multi", 4'b0011, PAT[8], 1'b1, 20);
        hold("an_zero", 4'b0000, PAT[8], 1'b1, 20);

        // anode all-off is illegal; then legal recapture clears digit 2 error
        hold("ca_d3_blank", 4'b1000, 7'b0000000, 1'b0, 6);
        hold("ca_d2_6", 4'b0100, PAT[6], 1'b0, 6);
        hold("cc_d0_1_frame", 4'b0001, PAT[1], 1'b1, 10);
        hold("cc_d0_same", 4'b0001, PAT[1], 1'b1, 6);

        // reset in the middle of a dwell
        hold("middwell", 4'b1000, PAT[4], 1'b1, 3);
        do_reset("reset_middwell");
        hold("after_rst_d3", 4'b1000, PAT[4], 1'b1, 5);

        // reset mid-frame discards the mask
        hold("mf_d0", 4'b0001, PAT[1], 1'b1, 5);
        hold("mf_d1", 4'b0010, PAT[2], 1'b1, 5);
        hold("mf_d2", 4'b0100, PAT[3], 1'b1, 5);
        do_reset("reset_midframe");
        hold("mf_d3", 4'b1000, PAT[4], 1'b1, 5);
        check("mf_final", 16'h4000, 4'b1000, 4'b0000, 1'b0);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive identical sampled cycles required before capture; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 seg_in  input  7  segment lines of a 4-digit multiplexed display; seg_in[6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
REQ-005 an_in  input  4  digit select, active-high one-hot; an_in[0] selects digit 0 (least significant).
REQ-006 LED_type_ctl  input  1  1 = common cathode (segments active-high), 0 = common anode (segments active-low).
REQ-007 bcd_out  output  16  recovered digits; bits [4i+3:4i] hold digit i.
REQ-008 digit_valid  output  4  bit i set when digit i holds a legally decoded value.
REQ-009 err_digit  output  4  bit i set when the last capture of digit i was an illegal pattern.
REQ-010 frame_done  output  1  one-cycle pulse when all 4 digits have been captured since the last pulse or reset.

Function
REQ-011 seg_in, an_in and LED_type_ctl SHALL be registered into a sample stage on every clock edge; all decoding uses the sampled values only.
REQ-012 Normalized pattern SHALL be sampled seg when LED_type_ctl=1, and bitwise inverse of sampled seg when LED_type_ctl=0.
REQ-013 Decode table (normalized abcdefg -> digit): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9; every other pattern SHALL be illegal.
REQ-014 FSM states SHALL be IDLE, SETTLE, CAPTURED.
REQ-015 IDLE: sampled an_in not one-hot (zero or multiple bits); no capture; stability counter held at 0.
REQ-016 Any change of sampled {an_in, seg_in, LED_type_ctl} versus the previous sample SHALL move to SETTLE (or IDLE if an_in not one-hot) with counter = 1.
REQ-017 SETTLE: counter increments each cycle the sample is unchanged; when counter reaches STABLE_CYCLES, the selected digit SHALL be captured on that edge and the FSM SHALL enter CAPTURED.
REQ-018 Output update SHALL occur on the (STABLE_CYCLES+1)-th rising edge after the inputs settle (5 edges at default).
REQ-019 Legal capture: write decoded digit into bcd_out slot, set digit_valid[i], clear err_digit[i].
REQ-020 Illegal capture: write 4'hF into slot, clear digit_valid[i], set err_digit[i].
REQ-021 CAPTURED: no further capture while the sample is unchanged (exactly one capture per dwell); counter saturates.
REQ-022 A captured-mask bit i SHALL be set on each capture of digit i (legal or illegal); when the mask becomes 4'b1111, frame_done SHALL pulse on that same edge and the mask SHALL clear.
REQ-023 Recapturing an already-masked digit before the frame completes SHALL overwrite its slot and SHALL NOT pulse frame_done.
REQ-024 Outputs of uncaptured digits SHALL hold their previous values indefinitely.
REQ-025 A dwell shorter than STABLE_CYCLES SHALL leave all outputs unchanged.

Reset
REQ-026 rst=1 SHALL immediately force bcd_out=16'h0000, digit_valid=4'b0000, err_digit=4'b0000, frame_done=0, FSM=IDLE, counter=0, captured mask=0, sample stage=0.
REQ-027 Reset asserted mid-dwell or mid-frame SHALL discard the partial capture and mask; after release a fresh STABLE_CYCLES dwell is required.

Verification
REQ-028 Common cathode, an_in=0001, seg_in=7'b1111110 held 5 edges -> bcd_out[3:0]=0, digit_valid=0001 on edge 5, not earlier.
REQ-029 Common anode, each digit i=0..3 driven with ~pattern of values 9,5,2,7 for 6 cycles each -> bcd_out=16'h7259, digit_valid=1111, one frame_done pulse with the digit-3 capture.
REQ-030 an_in=0100, seg_in=7'b1010101 (common cathode) held 5 edges -> bcd_out[11:8]=F, err_digit=0100, digit_valid[2]=0.
REQ-031 an_in=0010 with seg_in toggling between patterns every 3 cycles -> no output change; then held 5 edges -> single capture.
REQ-032 an_in=0011 or 0000 held 20 cycles -> no capture, all outputs unchanged.
REQ-033 rst pulsed after digits 0..2 captured, then digit 3 captured -> no frame_done; outputs zero except digit 3.
